// File: rtl/pzcorebus_packer_write_sequencer.sv
// Queues write-command lengths and sequences data-FIFO beats into per-command bursts; first beat 2 cycles after push.
// Backpressure: o_cmd_ready drops when the length queue is full; beats stall on !i_fifo_valid or !i_mdata_accept.
module pzcorebus_packer_write_sequencer #(
    parameter int LENGTH_WIDTH = 8,
    parameter int MAX_PENDING  = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_clear,
    input  logic                               i_cmd_valid,
    input  logic [LENGTH_WIDTH-1:0]            i_cmd_length,
    output logic                               o_cmd_ready,
    input  logic                               i_fifo_valid,
    output logic                               o_fifo_pop,
    output logic                               o_mdata_valid,
    input  logic                               i_mdata_accept,
    output logic                               o_mdata_last,
    output logic [$clog2(MAX_PENDING+2)-1:0]   o_pending,
    output logic                               o_busy
);
    localparam int PTR_W  = $clog2(MAX_PENDING);
    localparam int CNT_W  = $clog2(MAX_PENDING+1);
    localparam int PEND_W = $clog2(MAX_PENDING+2);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state_q, state_d;
    logic [LENGTH_WIDTH-1:0] beat_q, beat_d;
    logic [LENGTH_WIDTH-1:0] mem_q [MAX_PENDING];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    push, pop, q_empty, xfer;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_PENDING-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign q_empty     = (count_q == '0);
    assign o_cmd_ready = (count_q != CNT_W'(MAX_PENDING));
    assign push        = i_cmd_valid && o_cmd_ready && !i_clear;
    assign o_pending   = PEND_W'(count_q) + PEND_W'(state_q == BURST);
    assign o_busy      = (state_q == BURST) || !q_empty;

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        pop           = 1'b0;
        xfer          = 1'b0;
        o_mdata_valid = 1'b0;
        o_fifo_pop    = 1'b0;
        o_mdata_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!q_empty) begin
                    pop     = 1'b1;
                    beat_d  = mem_q[rd_ptr_q];
                    state_d = BURST;
                end
            end
            BURST: begin
                xfer          = i_fifo_valid && i_mdata_accept;
                o_mdata_valid = i_fifo_valid;
                o_fifo_pop    = xfer;
                o_mdata_last  = (beat_q == '0);
                if (xfer) begin
                    if (beat_q != '0) begin
                        beat_d = beat_q - LENGTH_WIDTH'(1);
                    end else if (!q_empty) begin
                        // reload on the final beat so back-to-back bursts have no bubble
                        pop    = 1'b1;
                        beat_d = mem_q[rd_ptr_q];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (i_clear) begin
            state_d       = IDLE;
            beat_d        = '0;
            pop           = 1'b0;
            o_mdata_valid = 1'b0;
            o_fifo_pop    = 1'b0;
            o_mdata_last  = 1'b0;
        end
    end

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            count_q <= count_d;
            if (i_clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= i_cmd_length;
    end
endmodule

// File: tb/tb_pzcorebus_packer_write_sequencer.sv
// Bench: beat-level reference model checked every cycle, plus directed literal scenarios and a random run.
`timescale 1ns/1ps
module tb_pzcorebus_packer_write_sequencer;
    localparam int LW   = 8;
    localparam int MAXP = 4;
    localparam int PW   = $clog2(MAXP+2);

    logic i_clk = 1'b0, i_rst_n = 1'b0, i_clear = 1'b0, i_cmd_valid = 1'b0;
    logic i_fifo_valid = 1'b0, i_mdata_accept = 1'b0;
    logic [LW-1:0] i_cmd_length = '0;
    logic o_cmd_ready, o_fifo_pop, o_mdata_valid, o_mdata_last, o_busy;
    logic [PW-1:0] o_pending;

    int tests = 0, fails = 0;
    int pop_total = 0, last_total = 0, beat_run = 0;
    int obs_lens[$];
    int acc_lens[$];
    int n_acc = 0;

    // model: lengths waiting, plus the burst in progress as beats still owed
    int mq[$];
    bit m_act = 1'b0;
    int m_left = 0;

    always #5 i_clk = ~i_clk;

    pzcorebus_packer_write_sequencer #(.LENGTH_WIDTH(LW), .MAX_PENDING(MAXP)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear),
        .i_cmd_valid(i_cmd_valid), .i_cmd_length(i_cmd_length), .o_cmd_ready(o_cmd_ready),
        .i_fifo_valid(i_fifo_valid), .o_fifo_pop(o_fifo_pop), .o_mdata_valid(o_mdata_valid),
        .i_mdata_accept(i_mdata_accept), .o_mdata_last(o_mdata_last),
        .o_pending(o_pending), .o_busy(o_busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (o_busy && n < 3000) begin
            step();
            n++;
        end
        chk(name, int'(o_busy), 0);
    endtask

    always @(negedge i_clk) begin
        bit e_ready, e_valid, e_pop, e_last, e_busy;
        int e_pend;
        if (!i_rst_n) begin
            mq.delete();
            m_act  = 1'b0;
            m_left = 0;
        end
        e_ready = mq.size() < MAXP;
        e_valid = m_act && i_fifo_valid && !i_clear;
        e_pop   = e_valid && i_mdata_accept;
        e_last  = m_act && (m_left == 1) && !i_clear;
        e_pend  = mq.size() + int'(m_act);
        e_busy  = m_act || (mq.size() != 0);
        chk("cmd_ready", int'(o_cmd_ready), int'(e_ready));
        chk("mdata_valid", int'(o_mdata_valid), int'(e_valid));
        chk("fifo_pop", int'(o_fifo_pop), int'(e_pop));
        chk("mdata_last", int'(o_mdata_last), int'(e_last));
        chk("pending", int'(o_pending), e_pend);
        chk("busy", int'(o_busy), int'(e_busy));

        if (i_rst_n && o_fifo_pop) begin
            pop_total++;
            beat_run++;
            if (o_mdata_last) begin
                last_total++;
                obs_lens.push_back(beat_run - 1);
                beat_run = 0;
            end
        end
        if (!i_rst_n || i_clear) beat_run = 0;

        if (i_rst_n) begin
            if (i_clear) begin
                mq.delete();
                m_act  = 1'b0;
                m_left = 0;
            end else begin
                if (m_act && e_pop) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (mq.size() != 0) m_left = mq.pop_front() + 1;
                        else m_act = 1'b0;
                    end
                end else if (!m_act && mq.size() != 0) begin
                    m_act  = 1'b1;
                    m_left = mq.pop_front() + 1;
                end
                if (i_cmd_valid && e_ready) begin
                    mq.push_back(int'(i_cmd_length));
                    acc_lens.push_back(int'(i_cmd_length));
                    n_acc++;
                end
            end
        end
    end

    initial begin
        #800000;
        fails++;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        logic [7:0] vb, pb, lb;
        logic [9:0] pb10, lb10;
        int pend[8];
        int p0, l0, sum, mism, beats, last_at, lasts;

        repeat (3) @(negedge i_clk);
        chk("rst_ready_lit", int'(o_cmd_ready), 1);
        chk("rst_pending_lit", int'(o_pending), 0);
        chk("rst_busy_lit", int'(o_busy), 0);
        chk("rst_valid_lit", int'(o_mdata_valid), 0);
        step();
        i_rst_n = 1'b1;
        step();

        // single length-3 command, no stalls
        i_fifo_valid = 1'b1; i_mdata_accept = 1'b1;
        p0 = pop_total;
        for (int k = 0; k < 8; k++) begin
            i_cmd_valid  = (k == 0);
            i_cmd_length = 8'd3;
            @(negedge i_clk);
            vb[k] = o_mdata_valid; pb[k] = o_fifo_pop;
            lb[k] = o_mdata_last && o_fifo_pop; pend[k] = int'(o_pending);
            step();
        end
        i_cmd_valid = 1'b0;
        chk("single_valid_bits", int'(vb), int'(8'b0011_1100));
        chk("single_pop_bits", int'(pb), int'(8'b0011_1100));
        chk("single_last_bits", int'(lb), int'(8'b0010_0000));
        chk("single_pend_k1", pend[1], 1);
        chk("single_pend_k5", pend[5], 1);
        chk("single_pend_k6", pend[6], 0);
        chk("single_pop_count", pop_total - p0, 4);

        // lengths 0,1,2 back to back
        for (int k = 0; k < 10; k++) begin
            i_cmd_valid  = (k < 3);
            i_cmd_length = LW'(k);
            @(negedge i_clk);
            pb10[k] = o_fifo_pop;
            lb10[k] = o_mdata_last && o_fifo_pop;
            step();
        end
        i_cmd_valid = 1'b0;
        chk("b2b_pop_bits", int'(pb10), int'(10'b00_1111_1100));
        chk("b2b_last_bits", int'(lb10), int'(10'b00_1001_0100));
        chk("b2b_idle_busy", int'(o_busy), 0);

        // fill the queue with the master refusing beats
        i_mdata_accept = 1'b0;
        p0 = pop_total; l0 = last_total;
        for (int k = 0; k < 6; k++) begin
            i_cmd_valid  = 1'b1;
            i_cmd_length = LW'(k);
            step();
        end
        repeat (2) step();
        @(negedge i_clk);
        chk("full_ready_lit", int'(o_cmd_ready), 0);
        chk("full_pending_lit", int'(o_pending), 5);
        chk("full_busy_lit", int'(o_busy), 1);
        step();
        i_cmd_valid = 1'b0;
        step();
        i_mdata_accept = 1'b1;
        drain("full_drain");
        chk("full_pop_count", pop_total - p0, 15);
        chk("full_last_count", last_total - l0, 5);

        // clear mid-burst with a concurrent push
        i_cmd_valid = 1'b1; i_cmd_length = 8'd10;
        step();
        i_cmd_valid = 1'b0;
        repeat (5) step();
        i_clear = 1'b1; i_cmd_valid = 1'b1; i_cmd_length = 8'd7;
        step();
        i_clear = 1'b0; i_cmd_valid = 1'b0;
        p0 = pop_total;
        @(negedge i_clk);
        chk("clear_pending_lit", int'(o_pending), 0);
        chk("clear_busy_lit", int'(o_busy), 0);
        repeat (6) step();
        chk("clear_no_pops", pop_total - p0, 0);

        // reset asserted mid-burst
        i_cmd_valid = 1'b1; i_cmd_length = 8'd20;
        step();
        i_cmd_valid = 1'b0;
        repeat (5) step();
        #2 i_rst_n = 1'b0;
        @(negedge i_clk);
        chk("arst_valid_lit", int'(o_mdata_valid), 0);
        chk("arst_pending_lit", int'(o_pending), 0);
        step();
        i_rst_n = 1'b1;
        step();
        p0 = pop_total; l0 = last_total;
        i_cmd_valid = 1'b1; i_cmd_length = 8'd1;
        step();
        i_cmd_valid = 1'b0;
        step();
        drain("arst_drain");
        chk("arst_pop_count", pop_total - p0, 2);
        chk("arst_last_count", last_total - l0, 1);

        // maximum length
        i_cmd_valid = 1'b1; i_cmd_length = 8'd255;
        step();
        i_cmd_valid = 1'b0;
        beats = 0; last_at = 0; lasts = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge i_clk);
            if (o_fifo_pop) begin
                beats++;
                if (o_mdata_last) begin lasts++; last_at = beats; end
            end
            step();
        end
        chk("max_beats", beats, 256);
        chk("max_last_at", last_at, 256);
        chk("max_last_count", lasts, 1);

        // random commands with random stalls
        acc_lens.delete(); obs_lens.delete(); n_acc = 0;
        p0 = pop_total; l0 = last_total;
        for (int cyc = 0; cyc < 20000 && n_acc < 200; cyc++) begin
            i_cmd_valid    = ($urandom % 2) == 0;
            i_cmd_length   = (($urandom % 20) == 0) ? LW'($urandom_range(0, 40)) : LW'($urandom_range(0, 7));
            i_fifo_valid   = ($urandom % 4) != 0;
            i_mdata_accept = ($urandom % 4) != 0;
            step();
        end
        i_cmd_valid = 1'b0; i_fifo_valid = 1'b1; i_mdata_accept = 1'b1;
        step();
        drain("rand_drain");
        sum = 0;
        foreach (acc_lens[i]) sum += acc_lens[i] + 1;
        mism = 0;
        foreach (acc_lens[i]) if (i >= obs_lens.size() || obs_lens[i] != acc_lens[i]) mism++;
        chk("rand_cmds_accepted", n_acc, 200);
        chk("rand_pop_count", pop_total - p0, sum);
        chk("rand_last_count", last_total - l0, 200);
        chk("rand_burst_count", obs_lens.size(), 200);
        chk("rand_order_mismatch", mism, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
